// File: rtl/gate_exercise_pkg.sv
// Shared types and reference model for the gate exerciser: FSM states,
// bit positions inside the packed gate_in bus, and the expected gate outputs.
package gate_exercise_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int AND_B   = 0;
  localparam int OR_B    = 1;
  localparam int NOT_A_B = 2;
  localparam int NOT_B_B = 3;
  localparam int NAND_B  = 4;
  localparam int NOR_B   = 5;
  localparam int XOR_B   = 6;
  localparam int XNOR_B  = 7;

  function automatic logic [7:0] expected_gates(input logic a, input logic b);
    logic [7:0] g;
    g          = '0;
    g[AND_B]   = a & b;
    g[OR_B]    = a | b;
    g[NOT_A_B] = ~a;
    g[NOT_B_B] = ~b;
    g[NAND_B]  = ~(a & b);
    g[NOR_B]   = ~(a | b);
    g[XOR_B]   = a ^ b;
    g[XNOR_B]  = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_exercise_checker.sv
// Compares sampled gate outputs against the reference model and accumulates
// per-vector failure flags and a failure count across one run.
module gate_exercise_checker
  import gate_exercise_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clear,
  input  logic       sample,
  input  logic [1:0] vec,
  input  logic [7:0] gate_in,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count,
  output logic       vec_mismatch
);

  // vec is {a,b}, so the reference inputs come straight from its bits.
  assign vec_mismatch = (gate_in != expected_gates(vec[1], vec[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec  <= '0;
      err_count <= '0;
    end else if (ena) begin
      if (clear) begin
        fail_vec  <= '0;
        err_count <= '0;
      end else if (sample && vec_mismatch) begin
        fail_vec[vec] <= 1'b1;
        err_count     <= err_count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/gate_exercise_sequencer.sv
// Self-test sequencer: steps {a,b} through 00..11, waits SETTLE_CYCLES per
// vector, then samples the gate block once and records pass/fail results.
module gate_exercise_sequencer
  import gate_exercise_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [7:0] gate_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [1:0] vec, vec_next;
  logic       busy_next, done_next, pass_next;
  logic       run_start, sample, vec_mismatch;

  assign a_out = vec[1];
  assign b_out = vec[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if (ena) begin
      state <= state_next;
      cnt   <= cnt_next;
      vec   <= vec_next;
      busy  <= busy_next;
      done  <= done_next;
      pass  <= pass_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    vec_next   = vec;
    busy_next  = busy;
    done_next  = done;
    pass_next  = pass;
    run_start  = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = SETTLE;
          cnt_next   = '0;
          vec_next   = '0;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          pass_next  = 1'b0;
          run_start  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_next = CHECK;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      CHECK: begin
        sample = 1'b1;
        if (vec == 2'd3) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          // The final vector's result lands in err_count on this same edge.
          pass_next  = (err_count == 3'd0) && !vec_mismatch;
        end else begin
          state_next = SETTLE;
          vec_next   = vec + 2'd1;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  gate_exercise_checker u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .clear        (run_start),
    .sample       (sample),
    .vec          (vec),
    .gate_in      (gate_in),
    .fail_vec     (fail_vec),
    .err_count    (err_count),
    .vec_mismatch (vec_mismatch)
  );

endmodule

// File: tb/tb_gate_exercise_sequencer.sv
// Bench: models the gate block in the loop with selectable faults and checks
// each run's results against a scoreboard of expected outcomes.
module tb_gate_exercise_sequencer;
  import gate_exercise_pkg::*;

  typedef struct {
    logic [3:0] fail_vec;
    logic [2:0] err_count;
    logic       pass;
    int         latency;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, ena, start;
  logic       a_out, b_out, busy, done, pass;
  logic [7:0] gate_in, gate_good;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  int         fault;
  int         checkCount = 0;
  int         errorCount = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  gate_exercise_sequencer #(.SETTLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .gate_in   (gate_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  // Stand-in for tt_um_digital_gates, packed {xnor,xor,nor,nand,not_b,not_a,or,and}.
  always_comb begin
    gate_good = {~(a_out ^ b_out), a_out ^ b_out, ~(a_out | b_out), ~(a_out & b_out),
                 ~b_out, ~a_out, a_out | b_out, a_out & b_out};
    gate_in = gate_good;
    if (fault == 1) gate_in[XOR_B] = 1'b0;
    else if (fault == 2) gate_in = 8'h00;
  end

  function automatic logic [11:0] outputsNow();
    return {a_out, b_out, busy, done, pass, err_count, fail_vec};
  endfunction

  task automatic checkOutput(input string tag, input int got, input int expv);
    checkCount++;
    if (got != expv) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpected(input logic [3:0] fv, input logic [2:0] ec,
                              input logic ps, input int lat);
    exp_t e;
    e.fail_vec  = fv;
    e.err_count = ec;
    e.pass      = ps;
    e.latency   = lat;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit hold);
    @(negedge clk);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_done", done, 0);
    checkOutput("accept_ab", {a_out, b_out}, 0);
  endtask

  task automatic waitResult(input int stall_at, input int stall_len);
    exp_t        e;
    int          cyc;
    bit          seen;
    logic [11:0] snap;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 200 && !seen) begin
      tick();
      cyc++;
      if (cyc == stall_at) begin
        snap = outputsNow();
        ena  = 1'b0;
        repeat (stall_len) begin
          tick();
          cyc++;
        end
        checkOutput("stall_freeze", int'(outputsNow()), int'(snap));
        ena = 1'b1;
      end
      if (done) seen = 1'b1;
      else if (stall_at < 0 && cyc % 5 == 2) begin
        checkOutput("vector_ab", {a_out, b_out}, cyc / 5);
        checkOutput("busy_in_run", busy, 1);
      end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    else if (sb.size() == 0) checkOutput("scoreboard_empty", 0, 1);
    else begin
      e = sb.pop_front();
      checkOutput("done_latency", cyc, e.latency);
      checkOutput("done_busy", busy, 0);
      checkOutput("pass", pass, int'(e.pass));
      checkOutput("err_count", err_count, int'(e.err_count));
      checkOutput("fail_vec", fail_vec, int'(e.fail_vec));
      checkOutput("done_ab", {a_out, b_out}, 3);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    fault = 0;
    repeat (2) tick();
    checkOutput("reset_outputs", int'(outputsNow()), 0);
    @(negedge clk);
    rst_n = 1'b1;

    pushExpected(4'b0000, 3'd0, 1'b1, 20);
    applyStimulus(1'b0);
    waitResult(-1, 0);
    repeat (3) tick();
    checkOutput("done_hold", done, 1);
    checkOutput("done_hold_ab", {a_out, b_out}, 3);

    fault = 1;
    pushExpected(4'b0110, 3'd2, 1'b0, 20);
    applyStimulus(1'b0);
    waitResult(-1, 0);

    fault = 2;
    pushExpected(4'b1111, 3'd4, 1'b0, 20);
    applyStimulus(1'b0);
    waitResult(-1, 0);

    pushExpected(4'b1111, 3'd4, 1'b0, 20);
    applyStimulus(1'b1);
    waitResult(-1, 0);
    tick();
    checkOutput("restart_done", done, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_err", err_count, 0);
    checkOutput("restart_fail", fail_vec, 0);
    checkOutput("restart_ab", {a_out, b_out}, 0);
    fault = 0;
    start = 1'b0;
    pushExpected(4'b0000, 3'd0, 1'b1, 20);
    waitResult(-1, 0);

    pushExpected(4'b0000, 3'd0, 1'b1, 27);
    applyStimulus(1'b0);
    waitResult(11, 7);

    applyStimulus(1'b0);
    repeat (9) tick();
    checkOutput("pre_reset_ab", {a_out, b_out}, 1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", int'(outputsNow()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pushExpected(4'b0000, 3'd0, 1'b1, 20);
    applyStimulus(1'b0);
    waitResult(-1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
